multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Main control FSM for the multicycle MIPS datapath. Decodes the opcode held in IR and sequences
//  PC, memory, IR, register file and ALU across cycles; drives AluOP (00 add, 01 sub, 10 funct)
//  into the ALU control decoder, which maps Func/AluOP to AluFunc. One instruction in flight.
// PARAMETERS
//  OP_RTYPE  6'b000000  R-type opcode (add/sub/and/or/slt via funct)
//  OP_LW     6'b100011  load word
//  OP_SW     6'b101011  store word
//  OP_BEQ    6'b000100  branch if equal
//  OP_ADDI   6'b001000  add immediate
//  OP_J      6'b000010  jump
// PORTS
//  clk          in   1  rising-edge clock
//  rst          in   1  asynchronous, active-high reset
//  Op           in   6  IR[31:26], valid from DECODE onward
//  PCWrite      out  1  unconditional PC load
//  PCWriteCond  out  1  PC load qualified by ALU Zero (beq)
//  IorD         out  1  0 = memory address from PC, 1 = from ALUOut
//  MemRead      out  1  memory read strobe
//  MemWrite     out  1  memory write strobe
//  IRWrite      out  1  load IR from memory data
//  MemtoReg     out  1  0 = write-back ALUOut, 1 = MDR
//  RegDst       out  1  0 = rt, 1 = rd
//  RegWrite     out  1  register file write
//  AluSrcA      out  1  0 = PC, 1 = A
//  AluSrcB      out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//  AluOP        out  2  00 add, 01 sub, 10 funct-decoded
//  PCSource     out  2  00 ALU result, 01 ALUOut, 10 jump target
//  illegal_op   out  1  one-cycle pulse in DECODE when Op matches no parameter
//  state_dbg    out  4  current state encoding
// BEHAVIOUR
//  - Moore FSM; outputs decoded from registered state only. Unlisted outputs = 0 in each state.
//  - Encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, REXE 6, RWB 7, BEQ 8,
//    JMP 9, IEXE 10, IWB 11. Codes 12-15 unreachable; if entered, next state = FETCH.
//  - FETCH: MemRead, IRWrite, IorD=0, AluSrcA=0, AluSrcB=01, AluOP=00, PCWrite, PCSource=00 -> DECODE
//  - DECODE: AluSrcA=0, AluSrcB=11, AluOP=00 (branch target to ALUOut). Next by Op:
//    LW/SW->MEMADR, RTYPE->REXE, BEQ->BEQ, J->JMP, ADDI->IEXE, other->FETCH with illegal_op=1
//  - MEMADR: AluSrcA=1, AluSrcB=10, AluOP=00 -> MEMRD (LW) / MEMWR (SW)
//  - MEMRD: MemRead, IorD=1 -> MEMWB.  MEMWB: RegWrite, MemtoReg=1, RegDst=0 -> FETCH
//  - MEMWR: MemWrite, IorD=1 -> FETCH
//  - REXE: AluSrcA=1, AluSrcB=00, AluOP=10 -> RWB.  RWB: RegWrite, RegDst=1, MemtoReg=0 -> FETCH
//  - BEQ: AluSrcA=1, AluSrcB=00, AluOP=01, PCWriteCond, PCSource=01 -> FETCH
//  - JMP: PCWrite, PCSource=10 -> FETCH
//  - IEXE: AluSrcA=1, AluSrcB=10, AluOP=00 -> IWB.  IWB: RegWrite, RegDst=0, MemtoReg=0 -> FETCH
//  - Cycles per instr: LW 5, SW 4, RTYPE 4, ADDI 4, BEQ 3, J 3, illegal 2.
//  - Reset: state=FETCH immediately (async); while rst=1 every output forced 0 (no stray
//    MemRead/PCWrite/IRWrite). First FETCH action on the first rising edge after rst falls.
//    Reset mid-instruction abandons it; no register/memory write issued afterwards.
//  - Op sampled only in DECODE (and MEMADR for LW/SW split); changes elsewhere ignored.
// CONFIGURATION
//  - MEM_WAIT_EN defined: adds input mem_ready (1 bit). FETCH, MEMRD, MEMWR hold state and
//    keep strobes asserted until mem_ready=1; IRWrite and PCWrite in FETCH asserted only in the
//    cycle mem_ready=1. Reset overrides a pending wait.
//  - Undefined: no mem_ready port; every memory state completes in one cycle.
// TESTING
//  - rst=1 with Op=6'h23 -> all outputs 0, state_dbg=0; release -> FETCH strobes on next cycle.
//  - Op=100011 (LW) -> states 0,1,2,3,4,0; MemtoReg=1 & RegWrite=1 only in state 4; 5 cycles.
//  - Op=000000 (R-type) -> AluOP=10 only in REXE; RegDst=1 with RegWrite in RWB; 4 cycles.
//  - Op=000100 (BEQ) -> BEQ state AluOP=01, PCWriteCond=1, PCSource=01; back to FETCH; J: PCSource=10.
//  - Op=111111 -> illegal_op=1 for exactly one cycle in DECODE, then FETCH, no RegWrite/MemWrite.
//  - MEM_WAIT_EN, SW, mem_ready low 3 cycles in MEMWR -> MemWrite held 4 cycles; rst mid-wait -> FETCH.

Source files
------------

// File: rtl/multicycle_control_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_if
//   Bundle between the multicycle main control FSM and the MIPS datapath.
//   master : the control FSM (drives control strobes, observes Op / mem_ready)
//   slave  : the datapath (consumes control strobes, supplies Op / mem_ready)
//   Signals:
//     Op[5:0]      IR[31:26] opcode, valid from DECODE onward
//     PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
//     MemtoReg, RegDst, RegWrite, AluSrcA        1-bit datapath controls
//     AluSrcB[1:0], AluOP[1:0], PCSource[1:0]    2-bit mux / ALU selects
//     illegal_op   one-cycle pulse in DECODE for an unknown opcode
//     state_dbg    current FSM state code
//     mem_ready    memory handshake, only present when MEM_WAIT_EN is defined
// -----------------------------------------------------------------------------
interface multicycle_control_if;
    logic [5:0] Op;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       AluSrcA;
    logic [1:0] AluSrcB;
    logic [1:0] AluOP;
    logic [1:0] PCSource;
    logic       illegal_op;
    logic [3:0] state_dbg;
`ifdef MEM_WAIT_EN
    logic       mem_ready;
`endif

    modport master (
`ifdef MEM_WAIT_EN
        input  mem_ready,
`endif
        input  Op,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
        output MemtoReg, RegDst, RegWrite, AluSrcA, AluSrcB, AluOP, PCSource,
        output illegal_op, state_dbg
    );

    modport slave (
`ifdef MEM_WAIT_EN
        output mem_ready,
`endif
        output Op,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
        input  MemtoReg, RegDst, RegWrite, AluSrcA, AluSrcB, AluOP, PCSource,
        input  illegal_op, state_dbg
    );
endinterface

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//   Main control FSM of the multicycle MIPS datapath. Decodes the opcode in IR
//   and sequences PC, memory, IR, register file and ALU over several cycles,
//   one instruction in flight at a time. Moore machine: every control output
//   is decoded from the registered state (illegal_op additionally looks at Op
//   while in DECODE).
//
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset; forces state FETCH and all outputs 0
//     bus  multicycle_control_if.master (Op in, control strobes out)
//
//   Configuration macro:
//     MEM_WAIT_EN  adds bus.mem_ready; FETCH / MEMRD / MEMWR stall until it is
//                  high. IRWrite and PCWrite in FETCH fire only in the ready
//                  cycle so the PC advances exactly once per fetch.
//
//   State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5,
//   REXE 6, RWB 7, BEQ 8, JMP 9, IEXE 10, IWB 11. Codes 12-15 return to FETCH.
// -----------------------------------------------------------------------------
module multicycle_control #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic                       clk,
    input  logic                       rst,
    multicycle_control_if.master       bus
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_REXE   = 4'd6;
    localparam logic [3:0] S_RWB    = 4'd7;
    localparam logic [3:0] S_BEQ    = 4'd8;
    localparam logic [3:0] S_JMP    = 4'd9;
    localparam logic [3:0] S_IEXE   = 4'd10;
    localparam logic [3:0] S_IWB    = 4'd11;

    logic [3:0] state_reg;
    logic [3:0] state_next;
    logic       mem_ok;
    logic       op_legal;

`ifdef MEM_WAIT_EN
    assign mem_ok = bus.mem_ready;
`else
    assign mem_ok = 1'b1;
`endif

    assign op_legal = (bus.Op == OP_RTYPE) || (bus.Op == OP_LW)   ||
                      (bus.Op == OP_SW)    || (bus.Op == OP_BEQ)  ||
                      (bus.Op == OP_ADDI)  || (bus.Op == OP_J);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH:  state_next = mem_ok ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (bus.Op == OP_LW || bus.Op == OP_SW) begin
                    state_next = S_MEMADR;
                end else if (bus.Op == OP_RTYPE) begin
                    state_next = S_REXE;
                end else if (bus.Op == OP_BEQ) begin
                    state_next = S_BEQ;
                end else if (bus.Op == OP_J) begin
                    state_next = S_JMP;
                end else if (bus.Op == OP_ADDI) begin
                    state_next = S_IEXE;
                end else begin
                    state_next = S_FETCH;
                end
            end
            // Only LW/SW reach MEMADR, so anything that is not a load is a store.
            S_MEMADR: state_next = (bus.Op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_next = mem_ok ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_next = S_FETCH;
            S_MEMWR:  state_next = mem_ok ? S_FETCH : S_MEMWR;
            S_REXE:   state_next = S_RWB;
            S_RWB:    state_next = S_FETCH;
            S_BEQ:    state_next = S_FETCH;
            S_JMP:    state_next = S_FETCH;
            S_IEXE:   state_next = S_IWB;
            S_IWB:    state_next = S_FETCH;
            default:  state_next = S_FETCH;
        endcase
    end

    // Output decode. Gated by rst so nothing strobes while reset is held,
    // even though the state register already sits in FETCH.
    always_comb begin
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.AluSrcA     = 1'b0;
        bus.AluSrcB     = 2'b00;
        bus.AluOP       = 2'b00;
        bus.PCSource    = 2'b00;
        bus.illegal_op  = 1'b0;
        if (!rst) begin
            case (state_reg)
                S_FETCH: begin
                    bus.MemRead = 1'b1;
                    bus.IRWrite = mem_ok;
                    bus.PCWrite = mem_ok;
                    bus.AluSrcB = 2'b01;
                end
                S_DECODE: begin
                    // Branch target computed speculatively into ALUOut.
                    bus.AluSrcB    = 2'b11;
                    bus.illegal_op = ~op_legal;
                end
                S_MEMADR: begin
                    bus.AluSrcA = 1'b1;
                    bus.AluSrcB = 2'b10;
                end
                S_MEMRD: begin
                    bus.MemRead = 1'b1;
                    bus.IorD    = 1'b1;
                end
                S_MEMWB: begin
                    bus.RegWrite = 1'b1;
                    bus.MemtoReg = 1'b1;
                end
                S_MEMWR: begin
                    bus.MemWrite = 1'b1;
                    bus.IorD     = 1'b1;
                end
                S_REXE: begin
                    bus.AluSrcA = 1'b1;
                    bus.AluOP   = 2'b10;
                end
                S_RWB: begin
                    bus.RegWrite = 1'b1;
                    bus.RegDst   = 1'b1;
                end
                S_BEQ: begin
                    bus.AluSrcA     = 1'b1;
                    bus.AluOP       = 2'b01;
                    bus.PCWriteCond = 1'b1;
                    bus.PCSource    = 2'b01;
                end
                S_JMP: begin
                    bus.PCWrite  = 1'b1;
                    bus.PCSource = 2'b10;
                end
                S_IEXE: begin
                    bus.AluSrcA = 1'b1;
                    bus.AluSrcB = 2'b10;
                end
                S_IWB: begin
                    bus.RegWrite = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.state_dbg = state_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//   Scoreboard bench for multicycle_control. For every instruction the expected
//   state sequence (and memory-ready pattern) is pushed to queues; each cycle one
//   entry is popped and the DUT state and packed control word are compared
//   against values derived from the control table. Op is scrambled in cycles
//   where the FSM must ignore it.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    logic [3:0] exp_q_state[$];
    logic       exp_q_rdy[$];

    multicycle_control_if bus();

    multicycle_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [16:0] obs_ctrl;
    assign obs_ctrl = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                       bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst,
                       bus.RegWrite, bus.AluSrcA, bus.AluSrcB, bus.AluOP,
                       bus.PCSource, bus.illegal_op};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic is_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

    // Expected control word straight from the per-state control table.
    function automatic logic [16:0] exp_ctrl(input logic [3:0] s, input logic [5:0] op,
                                             input logic rdy);
        logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, ill;
        logic [1:0] asb, aop, pcs;
        {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, ill} = '0;
        asb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (s)
            4'd0:  begin mr = 1; irw = rdy; pcw = rdy; asb = 2'b01; end
            4'd1:  begin asb = 2'b11; ill = !is_legal(op); end
            4'd2:  begin asa = 1; asb = 2'b10; end
            4'd3:  begin mr = 1; iord = 1; end
            4'd4:  begin rw = 1; m2r = 1; end
            4'd5:  begin mw = 1; iord = 1; end
            4'd6:  begin asa = 1; aop = 2'b10; end
            4'd7:  begin rw = 1; rd = 1; end
            4'd8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            4'd9:  begin pcw = 1; pcs = 2'b10; end
            4'd10: begin asa = 1; asb = 2'b10; end
            4'd11: begin rw = 1; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs, ill};
    endfunction

    task automatic push(input logic [3:0] s, input logic r);
        exp_q_state.push_back(s);
        exp_q_rdy.push_back(r);
    endtask

    // Push the expected sequence for one instruction; stall cycles only in MEMWR.
    task automatic push_instr(input logic [5:0] op, input int memwr_wait);
        push(4'd0, 1'b1);
        push(4'd1, 1'b1);
        case (op)
            OP_LW:    begin push(4'd2, 1); push(4'd3, 1); push(4'd4, 1); end
            OP_SW:    begin
                push(4'd2, 1);
                for (int i = 0; i < memwr_wait; i++) push(4'd5, 1'b0);
                push(4'd5, 1);
            end
            OP_RTYPE: begin push(4'd6, 1); push(4'd7, 1); end
            OP_BEQ:   push(4'd8, 1);
            OP_J:     push(4'd9, 1);
            OP_ADDI:  begin push(4'd10, 1); push(4'd11, 1); end
            default:  ;
        endcase
    endtask

    // Entered at a negedge with the DUT in FETCH; consumes the queues one
    // cycle at a time and returns at the negedge of the following FETCH.
    task automatic run_instr(input logic [5:0] op, input int memwr_wait);
        logic [3:0] s;
        logic       r;
        push_instr(op, memwr_wait);
        while (exp_q_state.size() > 0) begin
            s = exp_q_state.pop_front();
            r = exp_q_rdy.pop_front();
            bus.Op = (s == 4'd1 || s == 4'd2) ? op : 6'($urandom);
`ifdef MEM_WAIT_EN
            bus.mem_ready = r;
`endif
            #1;
            chk($sformatf("op%02h state", op), 32'(bus.state_dbg), 32'(s));
            chk($sformatf("op%02h ctrl s%0d", op, s), 32'(obs_ctrl), 32'(exp_ctrl(s, op, r)));
            @(negedge clk);
        end
    endtask

    logic [5:0] ops[6] = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI};

    initial begin
        bus.Op = 6'h23;
`ifdef MEM_WAIT_EN
        bus.mem_ready = 1'b1;
`endif
        // Reset held across clock edges: nothing may strobe.
        repeat (3) @(negedge clk);
        chk("rst state", 32'(bus.state_dbg), 32'd0);
        chk("rst ctrl", 32'(obs_ctrl), 32'd0);
        rst = 1'b0;

        // Directed instruction mix, including illegal opcodes.
        run_instr(OP_LW, 0);
        run_instr(OP_RTYPE, 0);
        run_instr(OP_BEQ, 0);
        run_instr(OP_J, 0);
        run_instr(OP_SW, 0);
        run_instr(OP_ADDI, 0);
        run_instr(6'b111111, 0);
        run_instr(6'b000001, 0);

        // Reset mid-instruction: SW abandoned in MEMADR, no write follows.
        bus.Op = OP_SW;
        @(negedge clk);
        @(negedge clk);
        chk("pre-abort state", 32'(bus.state_dbg), 32'd2);
        rst = 1'b1;
        #1;
        chk("abort state", 32'(bus.state_dbg), 32'd0);
        chk("abort ctrl", 32'(obs_ctrl), 32'd0);
        @(negedge clk);
        chk("abort hold ctrl", 32'(obs_ctrl), 32'd0);
        rst = 1'b0;
        run_instr(OP_LW, 0);

`ifdef MEM_WAIT_EN
        // Store stalled three cycles in MEMWR: MemWrite held for four.
        run_instr(OP_SW, 3);
`endif

        // Random mix of legal and arbitrary opcodes.
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 3) == 0) run_instr(6'($urandom), 0);
            else run_instr(ops[$urandom_range(0, 5)], 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
